// File: rtl/regfile_sb.sv
// Multi-port integer register file with a busy scoreboard for
// long-latency results; reads are combinational with optional forwarding.
module regfile_sb #(
    parameter int DATA_W   = 32,
    parameter int NREGS    = 32,
    parameter int NRD      = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1,
    localparam int AW      = $clog2(NREGS),
    localparam int CW      = $clog2(NREGS + 1)
) (
    input  logic                  clk,
    input  logic                  clr,
    input  logic [NRD*AW-1:0]     rd_addr,
    output logic [NRD*DATA_W-1:0] rd_data,
    output logic [NRD-1:0]        rd_busy,
    input  logic                  we0,
    input  logic [AW-1:0]         wa0,
    input  logic [DATA_W-1:0]     wd0,
    input  logic                  we1,
    input  logic [AW-1:0]         wa1,
    input  logic [DATA_W-1:0]     wd1,
    input  logic                  bset,
    input  logic [AW-1:0]         bset_addr,
    output logic [CW-1:0]         busy_cnt,
    output logic                  any_busy
);

    localparam bit ZR  = (ZERO_REG != 0);
    localparam bit BYP = (BYPASS != 0);

    logic [DATA_W-1:0] mem_q [NREGS];
    logic [NREGS-1:0]  busy_q, busy_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              w0_en, w1_en, bs_en;
    logic              cnt_inc, cnt_dec;

    function automatic logic is_zero(input logic [AW-1:0] a);
        return ZR && (a == '0);
    endfunction

    // Qualified strobes: nothing lands in r0 or while reset is held
    assign w0_en = we0 && !clr && !is_zero(wa0);
    assign w1_en = we1 && !clr && !is_zero(wa1);
    assign bs_en = bset && !clr && !is_zero(bset_addr);

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            for (int r = 0; r < NREGS; r++) begin
                mem_q[r] <= '0;
            end
        end else begin
            for (int r = 0; r < NREGS; r++) begin
                if (w0_en && wa0 == AW'(r)) begin
                    mem_q[r] <= wd0;
                end else if (w1_en && wa1 == AW'(r)) begin
                    mem_q[r] <= wd1;
                end
            end
        end
    end

    // Issue of a new op outranks completion of the old one
    always_comb begin
        busy_d = busy_q;
        if (w1_en) begin
            busy_d[wa1] = 1'b0;
        end
        if (bs_en) begin
            busy_d[bset_addr] = 1'b1;
        end
    end

    assign cnt_inc = bs_en && !busy_q[bset_addr];
    assign cnt_dec = w1_en && busy_q[wa1]
                   && !(bs_en && bset_addr == wa1);

    always_comb begin
        cnt_d = cnt_q;
        if (cnt_inc && !cnt_dec) begin
            cnt_d = cnt_q + CW'(1);
        end else if (cnt_dec && !cnt_inc) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            busy_q <= '0;
            cnt_q  <= '0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
        end
    end

    assign busy_cnt = cnt_q;
    assign any_busy = (cnt_q != '0);

    for (genvar g = 0; g < NRD; g++) begin : g_rd
        logic [AW-1:0] a;
        logic          hit0, hit1;

        assign a    = rd_addr[g*AW +: AW];
        assign hit0 = BYP && w0_en && (wa0 == a);
        assign hit1 = BYP && w1_en && (wa1 == a);

        assign rd_data[g*DATA_W +: DATA_W] =
            is_zero(a) ? '0  :
            hit0       ? wd0 :
            hit1       ? wd1 :
                         mem_q[a];

        assign rd_busy[g] = busy_q[a] && !hit1;
    end

endmodule

// File: tb/tb_regfile_sb.sv
// Bench for regfile_sb: directed vector table, reset/fill sequences,
// and randomized traffic against an array-based reference model.
module tb_regfile_sb;

    localparam int DW  = 32;
    localparam int NR  = 32;
    localparam int NRD = 2;
    localparam int AW  = 5;
    localparam int CW  = 6;

    logic              clk = 1'b0;
    logic              clr;
    logic [NRD*AW-1:0] rd_addr;
    logic [NRD*DW-1:0] rd_data, rd_data_nb;
    logic [NRD-1:0]    rd_busy, rd_busy_nb;
    logic              we0, we1, bset;
    logic [AW-1:0]     wa0, wa1, bset_addr;
    logic [DW-1:0]     wd0, wd1;
    logic [CW-1:0]     busy_cnt, busy_cnt_nb;
    logic              any_busy, any_busy_nb;

    regfile_sb dut (
        .clk(clk), .clr(clr),
        .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
        .we0(we0), .wa0(wa0), .wd0(wd0),
        .we1(we1), .wa1(wa1), .wd1(wd1),
        .bset(bset), .bset_addr(bset_addr),
        .busy_cnt(busy_cnt), .any_busy(any_busy)
    );

    regfile_sb #(.BYPASS(0)) dut_nb (
        .clk(clk), .clr(clr),
        .rd_addr(rd_addr), .rd_data(rd_data_nb), .rd_busy(rd_busy_nb),
        .we0(we0), .wa0(wa0), .wd0(wd0),
        .we1(we1), .wa1(wa1), .wd1(wd1),
        .bset(bset), .bset_addr(bset_addr),
        .busy_cnt(busy_cnt_nb), .any_busy(any_busy_nb)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic idle();
        we0 = 1'b0; wa0 = '0; wd0 = '0;
        we1 = 1'b0; wa1 = '0; wd1 = '0;
        bset = 1'b0; bset_addr = '0;
    endtask

    typedef struct {
        logic          we0;
        logic [AW-1:0] wa0;
        logic [31:0]   wd0;
        logic          we1;
        logic [AW-1:0] wa1;
        logic [31:0]   wd1;
        logic          bs;
        logic [AW-1:0] ba;
        logic [AW-1:0] r0, r1;
        logic [31:0]   e0, e1, enb;
        logic          b0, b1;
        logic [CW-1:0] cnt;
    } vec_t;

    vec_t tbl[11];

    logic [31:0] m_mem [NR];
    bit          m_busy [NR];

    initial begin
        tbl[0]  = '{1, 3, 32'hDEADBEEF, 0, 0, 0, 0, 0, 3, 0,
                    32'hDEADBEEF, 0, 0, 0, 0, 0};
        tbl[1]  = '{0, 0, 0, 0, 0, 0, 0, 0, 3, 0,
                    32'hDEADBEEF, 0, 32'hDEADBEEF, 0, 0, 0};
        tbl[2]  = '{1, 9, 32'h11, 1, 9, 32'h22, 0, 0, 9, 3,
                    32'h11, 32'hDEADBEEF, 0, 0, 0, 0};
        tbl[3]  = '{0, 0, 0, 0, 0, 0, 1, 4, 9, 4,
                    32'h11, 0, 32'h11, 0, 0, 1};
        tbl[4]  = '{0, 0, 0, 0, 0, 0, 0, 0, 9, 4,
                    32'h11, 0, 32'h11, 0, 1, 1};
        tbl[5]  = '{0, 0, 0, 1, 4, 32'h55, 0, 0, 4, 4,
                    32'h55, 32'h55, 0, 0, 0, 0};
        tbl[6]  = '{0, 0, 0, 0, 0, 0, 1, 4, 4, 4,
                    32'h55, 32'h55, 32'h55, 0, 0, 1};
        tbl[7]  = '{0, 0, 0, 1, 4, 32'h66, 1, 4, 4, 4,
                    32'h66, 32'h66, 32'h55, 0, 0, 1};
        tbl[8]  = '{1, 0, 32'hFF, 0, 0, 0, 1, 0, 4, 0,
                    32'h66, 0, 32'h66, 1, 0, 1};
        tbl[9]  = '{0, 0, 0, 0, 0, 0, 0, 0, 4, 0,
                    32'h66, 0, 32'h66, 1, 0, 1};
        tbl[10] = '{0, 0, 0, 1, 10, 32'h0A, 0, 0, 10, 4,
                    32'h0A, 32'h66, 0, 0, 1, 1};

        idle();
        rd_addr = '0;
        clr = 1'b1;
        #2;
        chk("rst_rd", rd_data[31:0], 0);
        chk("rst_cnt", 32'(busy_cnt), 0);
        chk("rst_any", 32'(any_busy), 0);
        @(negedge clk);
        clr = 1'b0;

        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            we0 = tbl[i].we0; wa0 = tbl[i].wa0; wd0 = tbl[i].wd0;
            we1 = tbl[i].we1; wa1 = tbl[i].wa1; wd1 = tbl[i].wd1;
            bset = tbl[i].bs; bset_addr = tbl[i].ba;
            rd_addr = {tbl[i].r1, tbl[i].r0};
            #1;
            chk($sformatf("v%0d_rd0", i), rd_data[31:0], tbl[i].e0);
            chk($sformatf("v%0d_rd1", i), rd_data[63:32], tbl[i].e1);
            chk($sformatf("v%0d_nb0", i), rd_data_nb[31:0], tbl[i].enb);
            chk($sformatf("v%0d_bz0", i), 32'(rd_busy[0]), 32'(tbl[i].b0));
            chk($sformatf("v%0d_bz1", i), 32'(rd_busy[1]), 32'(tbl[i].b1));
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_cnt", i), 32'(busy_cnt), 32'(tbl[i].cnt));
        end

        // Asynchronous clear in the middle of a cycle
        @(negedge clk);
        idle();
        we0 = 1'b1; wa0 = 5; wd0 = 32'h1234;
        @(negedge clk);
        idle();
        bset = 1'b1; bset_addr = 7;
        @(negedge clk);
        idle();
        rd_addr = {5'd7, 5'd5};
        #1;
        chk("pre_clr_rd", rd_data[31:0], 32'h1234);
        chk("pre_clr_bz", 32'(rd_busy[1]), 1);
        chk("pre_clr_cnt", 32'(busy_cnt), 2);
        #1 clr = 1'b1;
        #1;
        chk("clr_rd", rd_data[31:0], 0);
        chk("clr_bz", 32'(rd_busy[1]), 0);
        chk("clr_cnt", 32'(busy_cnt), 0);
        chk("clr_any", 32'(any_busy), 0);
        #1 clr = 1'b0;

        // Fill every non-zero register, then saturate
        for (int k = 1; k < NR; k++) begin
            @(negedge clk);
            bset = 1'b1; bset_addr = AW'(k);
            @(posedge clk);
            #1;
            chk($sformatf("fill_cnt%0d", k), 32'(busy_cnt), k);
        end
        @(negedge clk);
        bset = 1'b1; bset_addr = 1;
        rd_addr = {5'd31, 5'd0};
        #1;
        chk("fill_bz31", 32'(rd_busy[1]), 1);
        chk("fill_bz0", 32'(rd_busy[0]), 0);
        @(posedge clk);
        #1;
        chk("fill_rep_cnt", 32'(busy_cnt), 31);
        chk("fill_any", 32'(any_busy), 1);

        @(negedge clk);
        idle();
        clr = 1'b1;
        #1 clr = 1'b0;
        for (int r = 0; r < NR; r++) begin
            m_mem[r] = '0;
            m_busy[r] = 0;
        end

        for (int c = 0; c < 2000; c++) begin
            logic [AW-1:0] ra [NRD];
            logic [31:0]   exp_d;
            bit            exp_b;
            int            nb;
            @(negedge clk);
            we0 = 1'($urandom_range(0, 1));
            we1 = 1'($urandom_range(0, 1));
            bset = ($urandom_range(0, 2) == 0);
            wa0 = AW'($urandom_range(0, c[0] ? 31 : 7));
            wa1 = AW'($urandom_range(0, c[1] ? 31 : 7));
            bset_addr = AW'($urandom_range(0, c[2] ? 31 : 7));
            wd0 = $urandom;
            wd1 = $urandom;
            for (int p = 0; p < NRD; p++) begin
                ra[p] = AW'($urandom_range(0, 7));
            end
            rd_addr = {ra[1], ra[0]};
            #1;
            for (int p = 0; p < NRD; p++) begin
                if (ra[p] == 0) exp_d = 0;
                else if (we0 && wa0 == ra[p]) exp_d = wd0;
                else if (we1 && wa1 == ra[p]) exp_d = wd1;
                else exp_d = m_mem[ra[p]];
                exp_b = m_busy[ra[p]] && !(we1 && wa1 == ra[p]);
                chk($sformatf("rnd%0d_rd%0d", c, p),
                    rd_data[p*DW +: DW], exp_d);
                chk($sformatf("rnd%0d_nb%0d", c, p),
                    rd_data_nb[p*DW +: DW], m_mem[ra[p]]);
                chk($sformatf("rnd%0d_bz%0d", c, p),
                    32'(rd_busy[p]), 32'(exp_b));
            end
            if (we1 && wa1 != 0) begin
                m_mem[wa1] = wd1;
                m_busy[wa1] = 0;
            end
            if (we0 && wa0 != 0) m_mem[wa0] = wd0;
            if (bset && bset_addr != 0) m_busy[bset_addr] = 1;
            nb = 0;
            for (int r = 0; r < NR; r++) nb += int'(m_busy[r]);
            @(posedge clk);
            #1;
            chk($sformatf("rnd%0d_cnt", c), 32'(busy_cnt), nb);
            chk($sformatf("rnd%0d_any", c), 32'(any_busy), 32'(nb != 0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
- Parametrised successor to the CPU's 2-read/1-write register file: configurable data width, register count and read-port count.
- Two write ports:
  - port 0 is the main pipeline writeback;
  - port 1 is writeback from long-latency units (mult/div, load miss).
- Holds a per-register busy scoreboard and busy counter so the hazard unit can stall on results still in flight.
- Sits between decode (reads, busy issue) and writeback (writes) in the integer core.

Parameters:
- DATA_W, 32, register width in bits
- NREGS, 32, number of registers (power of two, >=2); AW = $clog2(NREGS)
- NRD, 2, number of read ports (1..4)
- ZERO_REG, 1, 1 = register 0 reads 0, ignores writes, never busy
- BYPASS, 1, 1 = same-cycle write data forwarded to reads

Ports:
- clk  in  1  clock, rising edge
- clr  in  1  asynchronous active-high reset
- rd_addr  in  NRD*AW  read addresses, port i at [i*AW +: AW]
- rd_data  out  NRD*DATA_W  read data, port i at [i*DATA_W +: DATA_W]
- rd_busy  out  NRD  busy flag of the addressed register, per port
- we0  in  1  write enable, port 0
- wa0  in  AW  write address, port 0
- wd0  in  DATA_W  write data, port 0
- we1  in  1  write enable, port 1 (also clears busy)
- wa1  in  AW  write address, port 1
- wd1  in  DATA_W  write data, port 1
- bset  in  1  mark register bset_addr busy (long-latency op issued)
- bset_addr  in  AW  register to mark busy
- busy_cnt  out  $clog2(NREGS+1)  number of registers currently busy
- any_busy  out  1  busy_cnt != 0

Behaviour:
Reset:
- clr high sets every register to 0, every busy bit to 0, and busy_cnt to 0 immediately, independent of clk.
- While clr is high, writes and bset are ignored.
- Deassertion takes effect at the next rising edge.

Writes:
- Writes commit on the rising edge of clk.
- we0 and we1 to the same address in the same cycle: port 0 data wins (younger instruction in program order).
- Writes to different addresses both commit.
- With ZERO_REG=1, writes to address 0 are dropped and bset to address 0 is ignored.

Reads (combinational, zero latency):
- With BYPASS=1, read-port priority is:
  1. we0 && wa0==addr (and addr!=0 when ZERO_REG) -> wd0;
  2. else we1 && wa1==addr -> wd1;
  3. else the stored value.
- With BYPASS=0, reads return stored contents only; a write is visible the cycle after its edge.
- With ZERO_REG=1, address 0 always reads 0.

Scoreboard:
- busy[bset_addr] is set on the edge where bset=1.
- busy[wa1] is cleared on the edge where we1=1.
- bset and we1 on the same address in the same cycle: set wins, and the bit stays 1 (new op issued).
- we0 does not affect busy.
- rd_busy[i] = busy[addr_i] && !(we1 && wa1==addr_i && BYPASS).
  - Completing data is already forwarded, so the reader need not stall.
  - A same-cycle bset is not visible until the next cycle.
- bset on a register that is already busy leaves it busy; busy_cnt is unchanged.
- we1 on a register that is not busy leaves the bit 0; busy_cnt is unchanged.

busy_cnt:
- Registered; equals the popcount of the busy bits after each edge.
- Changes by -1, 0 or +1 per cycle.
- Never wraps: the maximum is NREGS-ZERO_REG.
- any_busy is combinational from busy_cnt.

Test Plan:
- Reset: pulse clr mid-cycle after writing r5=0x1234 and bset r7 -> rd_data=0 for r5, rd_busy r7=0, busy_cnt=0, all before the next edge.
- Write/bypass: we0 wa0=3 wd0=0xDEADBEEF, rd_addr[0]=3 -> rd_data[0]=0xDEADBEEF in the same cycle with BYPASS=1; with BYPASS=0, the value appears only after the edge.
- Port conflict: we0 and we1 both to r9, wd0=0x11 and wd1=0x22 -> r9 reads 0x11 after the edge, and the same-cycle bypass also returns 0x11.
- Scoreboard: bset r4 -> next cycle rd_busy=1 and busy_cnt=1.
  - we1 wa1=4 wd1=0x55 -> rd_busy=0 and rd_data=0x55 in that same cycle.
  - busy_cnt=0 after the edge.
- Simultaneous set/clear: r4 busy, then bset r4 plus we1 wa1=4 in one cycle -> r4 holds the wd1 data, busy stays 1, busy_cnt stays 1.
- Zero register: we0 wa0=0 wd0=0xFF plus bset r0 -> r0 reads 0, rd_busy=0, busy_cnt unchanged.
- Fill: bset r1..r31 on consecutive cycles -> busy_cnt=31 and any_busy=1; a repeat bset r1 leaves it at 31.
